// File: rtl/ram_program_loader_if.sv
// Byte-stream input and RAM write-port bundle between a program source and the loader.
// The slave modport is the loader's view; the master modport is the source/RAM-path side.
interface ram_program_loader_if #(
    parameter int ADDRESS_WIDTH = 4,
    parameter int RAM_WIDTH     = 8
);
    logic                     i_valid;
    logic [RAM_WIDTH-1:0]     i_data;
    logic                     i_last;
    logic                     o_ready;
    logic                     o_ram_sel;
    logic [ADDRESS_WIDTH-1:0] o_ram_address;
    logic                     o_ram_load_enable;
    logic [RAM_WIDTH-1:0]     o_ram_load_data;

    modport slave (
        input  i_valid, i_data, i_last,
        output o_ready, o_ram_sel, o_ram_address, o_ram_load_enable, o_ram_load_data
    );

    modport master (
        output i_valid, i_data, i_last,
        input  o_ready, o_ram_sel, o_ram_address, o_ram_load_enable, o_ram_load_data
    );
endinterface

// File: rtl/ram_program_loader.sv
// Holds the CPU, streams a program into RAM at <= 1 byte per clk_en period, then restarts the CPU.
// Single-entry holding register: o_ready drops from acceptance until the clk_en write commits.
module ram_program_loader #(
    parameter int ADDRESS_WIDTH = 4,
    parameter int RAM_WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clk_en,
    input  logic                 i_start,
    input  logic                 i_at_fetch,
    ram_program_loader_if.slave  bus,
    output logic                 o_cpu_hold,
    output logic                 o_cpu_restart,
    output logic                 o_busy,
    output logic                 o_done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAIN   = 2'd1,
        LOAD    = 2'd2,
        RESTART = 2'd3
    } state_t;

    localparam logic [ADDRESS_WIDTH-1:0] TOP_ADDR = '1;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic                     pend_q, pend_d;
    logic [RAM_WIDTH-1:0]     data_q, data_d;
    logic                     last_q, last_d;
    logic                     done_q, done_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            pend_q  <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pend_q  <= pend_d;
            data_q  <= data_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pend_d  = pend_q;
        data_d  = data_q;
        last_d  = last_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Only take the RAM at an instruction boundary so no half-executed step sees it change.
                if (clk_en && i_at_fetch) begin
                    state_d = LOAD;
                    addr_d  = '0;
                    pend_d  = 1'b0;
                end
            end
            LOAD: begin
                if (pend_q) begin
                    if (clk_en) begin
                        pend_d = 1'b0;
                        if (last_q || (addr_q == TOP_ADDR)) begin
                            state_d = RESTART;
                        end else begin
                            addr_d = addr_q + ADDRESS_WIDTH'(1);
                        end
                    end
                end else if (bus.i_valid) begin
                    pend_d = 1'b1;
                    data_d = bus.i_data;
                    last_d = bus.i_last;
                end
            end
            RESTART: begin
                if (clk_en) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode only registered state, so o_ready has no path from i_valid.
    assign o_cpu_hold             = (state_q != IDLE);
    assign o_cpu_restart          = (state_q == RESTART);
    assign o_busy                 = (state_q != IDLE);
    assign o_done                 = done_q;
    assign bus.o_ram_sel          = (state_q == LOAD);
    assign bus.o_ready            = (state_q == LOAD) && !pend_q;
    assign bus.o_ram_load_enable  = (state_q == LOAD) && pend_q;
    assign bus.o_ram_address      = addr_q;
    assign bus.o_ram_load_data    = data_q;

    ready_implies_sel: assert property (@(posedge clk) disable iff (!rst_n)
        bus.o_ready |-> bus.o_ram_sel);

    restart_leaves_on_en: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == RESTART && clk_en) |=> (state_q == IDLE));

endmodule
